mesi_isc_fifo_rr_arb: RTL
=========================

Name: mesi_isc_fifo_rr_arb

Overview:
- Round-robin arbiter that shares one downstream consumer between NUM_PORTS per-CPU request FIFOs (mesi_isc_basic_fifo instances).
- Monitors each FIFO's empty flag and head data, pops the granted FIFO with a one-cycle rd pulse, and captures the popped entry into a single registered output stage.
- The output stage has a valid/ready handshake and a source-port tag.
- Sits between the per-CPU main-bus request FIFOs and the broadcast/snoop sequencer.

Parameters:
- NUM_PORTS, 4, number of requester FIFOs (≥2).
- NUM_PORTS_LOG2, 2, width of port index; equals clog2(NUM_PORTS).
- DATA_WIDTH, 32, width of each FIFO entry.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- fifo_empty_i  input  NUM_PORTS  status_empty_o of each FIFO; bit p = port p.
- fifo_data_i  input  NUM_PORTS*DATA_WIDTH  data_o of each FIFO; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- fifo_rd_o  output  NUM_PORTS  rd_i pulse to each FIFO; at most one bit set per cycle.
- port_mask_i  input  NUM_PORTS  1 = port eligible for arbitration.
- flush_i  input  1  synchronous flush of the output stage.
- out_valid_o  output  1  output stage holds an entry.
- out_data_o  output  DATA_WIDTH  captured entry.
- out_src_o  output  NUM_PORTS_LOG2  port index the entry came from.
- out_ready_i  input  1  consumer accepts the entry when out_valid_o & out_ready_i.

Behaviour:
- Reset values: rst asynchronously sets all registers:
  - fifo_rd_o=0, out_valid_o=0, out_data_o=0, out_src_o=0.
  - Last-grant pointer last_gnt = NUM_PORTS-1, so port 0 has first priority.
- Request vector: req = ~fifo_empty_i & port_mask_i.
- Load enable: load_ok = ~out_valid_o | out_ready_i (stage empty, or being drained this cycle).
- Grant search:
  - Combinational, circular from (last_gnt+1) mod NUM_PORTS upward.
  - First set req bit wins.
  - Wrap past NUM_PORTS-1 to 0 is required.
- Pop: when load_ok & |req & ~flush_i:
  - fifo_rd_o[g] is asserted combinationally in this cycle.
  - At the clock edge: out_data_o <= fifo_data_i slice g; out_src_o <= g; out_valid_o <= 1; last_gnt <= g.
  - The FIFO head is valid in the same cycle empty is low, so pop-to-valid latency is 1 cycle.
- Drain without reload: out_valid_o & out_ready_i & no req -> out_valid_o <= 0; out_data_o and out_src_o hold.
- Hold: out_valid_o & ~out_ready_i:
  - fifo_rd_o = 0.
  - out_data_o and out_src_o are stable until accepted (no change while valid & not ready).
- Throughput: one entry per cycle sustained when out_ready_i is held high and requests exist.
  - Back-to-back grants to the same port are allowed only when it is the sole requester.
  - A FIFO's empty flag updates on the pop edge, so the next-cycle req is accurate; no extra bubble.
- Fairness: with k ports continuously requesting, each is granted exactly once per k grants.
  - last_gnt changes only on a pop.
- Mask: port_mask_i changes take effect the same cycle; a masked port is never popped.
  - A masked port's pending entry is untouched.
- Flush: flush_i has highest priority after reset.
  - Next edge: out_valid_o <= 0.
  - fifo_rd_o = 0 in that cycle; no pop.
  - last_gnt holds.
  - The entry in the stage is discarded (not accepted even if out_ready_i=1).
- Reset mid-transfer: the entry in the output stage is lost and no rd pulse follows; the FIFOs are reset on the same rst.
- Invariant: fifo_rd_o is onehot0, and never set for a port whose fifo_empty_i=1 (no underflow).

Test Plan:
- Reset, then ports 0 and 2 non-empty, data 0xA0 and 0xA2, out_ready_i=1 -> fifo_rd_o:
  - 0001 in cycle 1, then 0100 in cycle 2.
  - out_data_o: 0xA0/src 0, then 0xA2/src 2.
  - out_valid_o high both cycles.
- All 4 ports hold 3 entries each, ready=1 -> grant order 0,1,2,3,0,1,2,3,0,1,2,3; 12 consecutive valid cycles; then out_valid_o=0.
- Port 1 only, 2 entries, out_ready_i=0 for 3 cycles after the first load:
  - Single rd pulse; out_data_o held 3 cycles.
  - Second pop occurs in the same cycle ready rises.
- last_gnt=3, only port 0 requesting -> wrap grant to port 0, out_src_o=0.
- port_mask_i=1101 with ports 1 and 3 non-empty -> only port 3 popped; port 1 entry retained; unmasking pops port 1 next.
- out_valid_o=1, flush_i=1 with ports requesting -> fifo_rd_o=0 that cycle; out_valid_o=0 next cycle; arbitration resumes after flush_i deasserts.

Source files
------------

// File: rtl/mesi_isc_fifo_rr_arb.sv
// Round-robin arbiter: pops one of NUM_PORTS request FIFOs per cycle into a registered
// valid/ready output stage tagged with the source port; pop-to-valid latency is one cycle.
module mesi_isc_fifo_rr_arb #(
  parameter int NUM_PORTS      = 4,
  parameter int NUM_PORTS_LOG2 = 2,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            fifo_empty_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data_i,
  output logic [NUM_PORTS-1:0]            fifo_rd_o,
  input  logic [NUM_PORTS-1:0]            port_mask_i,
  input  logic                            flush_i,
  output logic                            out_valid_o,
  output logic [DATA_WIDTH-1:0]           out_data_o,
  output logic [NUM_PORTS_LOG2-1:0]       out_src_o,
  input  logic                            out_ready_i
);

  logic [NUM_PORTS-1:0]      req;
  logic                      load_ok;
  logic                      pop;
  logic                      gnt_vld;
  logic [NUM_PORTS_LOG2-1:0] gnt_idx;
  logic [NUM_PORTS_LOG2-1:0] cand;
  logic [NUM_PORTS_LOG2-1:0] last_gnt;
  logic [DATA_WIDTH-1:0]     port_dat [NUM_PORTS];

  function automatic logic [NUM_PORTS_LOG2-1:0] port_at(
    input logic [NUM_PORTS_LOG2-1:0] base,
    input int                        off
  );
    int s;
    s = (int'(base) + off) % NUM_PORTS;
    return s[NUM_PORTS_LOG2-1:0];
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_dat[p] = fifo_data_i[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign req     = ~fifo_empty_i & port_mask_i;
  assign load_ok = ~out_valid_o | out_ready_i;

  // Scan starts just after the last winner and wraps, so the previous winner is checked last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = port_at(last_gnt, i);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // rd is held off during reset since the stage cannot capture the popped head then.
  assign pop = load_ok & gnt_vld & ~flush_i & ~rst;

  always_comb begin
    fifo_rd_o = '0;
    if (pop) begin
      fifo_rd_o[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_src_o   <= '0;
      last_gnt    <= NUM_PORTS_LOG2'(NUM_PORTS - 1);
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (pop) begin
      out_valid_o <= 1'b1;
      out_data_o  <= port_dat[gnt_idx];
      out_src_o   <= gnt_idx;
      last_gnt    <= gnt_idx;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
